jtframe_rom_rq: RTL and testbench



---
 rtl/jtframe_rom_rq_pkg.sv | 6 +
 rtl/jtframe_rom_rq.sv | 106 ++++++++++
 tb/tb_jtframe_rom_rq.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/jtframe_rom_rq_pkg.sv
// Shared widths and types for the ROM request slot.
package jtframe_rom_rq_pkg;
  localparam int SDRAM_AW = 22;
  typedef logic [SDRAM_AW-1:0] sdram_addr_t;
  typedef logic [31:0]         line_t;
endpackage

// File: rtl/jtframe_rom_rq.sv
// Read-only SDRAM request slot with a two-entry, 32-bit-line cache.
// Entry 0 always holds the newest fill; entry 1 holds the one before it.
module jtframe_rom_rq
  import jtframe_rom_rq_pkg::*;
#(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int REPACK = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [21:0]       offset,
  input  logic [AW-1:0]     addr,
  input  logic              addr_ok,
  output logic [21:0]       sdram_addr,
  input  logic [31:0]       din,
  input  logic              din_ok,
  input  logic              we,
  output logic              req,
  output logic              data_ok,
  output logic [DW-1:0]     dout
);

  logic [AW-1:0] addr_req;
  logic [AW-1:0] cached_addr0, cached_addr1;
  line_t         cached_data0, cached_data1;
  logic          valid0, valid1;
  logic          hit0, hit1, hit;
  line_t         line;
  sdram_addr_t   haddr;
  logic [DW-1:0] dout_c;
  logic          data_ok_c;

  // Line alignment, half-word translation and field select depend on DW
  generate
    if (DW == 8) begin : g_dw8
      assign addr_req = {addr[AW-1:2], 2'b00};
      assign haddr    = SDRAM_AW'(addr_req >> 1);
      assign dout_c   = line[{addr[1:0], 3'b000} +: 8];
    end else if (DW == 16) begin : g_dw16
      assign addr_req = {addr[AW-1:1], 1'b0};
      assign haddr    = SDRAM_AW'(addr_req);
      assign dout_c   = line[{addr[0], 4'b0000} +: 16];
    end else begin : g_dw32
      assign addr_req = addr;
      assign haddr    = SDRAM_AW'({addr_req, 1'b0});
      assign dout_c   = line;
    end
  endgenerate

  assign sdram_addr = offset + haddr;

  assign hit0      = valid0 && (cached_addr0 == addr_req);
  assign hit1      = valid1 && (cached_addr1 == addr_req);
  assign hit       = hit0 | hit1;
  assign line      = hit0 ? cached_data0 : cached_data1;
  assign req       = addr_ok && !hit && !we;
  assign data_ok_c = addr_ok && hit;

  // A fill concurrent with clr still lands in entry 0; the shifted entry dies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cached_addr0 <= '0;
      cached_addr1 <= '0;
      cached_data0 <= '0;
      cached_data1 <= '0;
      valid0       <= 1'b0;
      valid1       <= 1'b0;
    end else if (we && din_ok) begin
      cached_addr1 <= cached_addr0;
      cached_data1 <= cached_data0;
      valid1       <= valid0 && !clr;
      cached_addr0 <= addr_req;
      cached_data0 <= din;
      valid0       <= 1'b1;
    end else if (clr) begin
      valid0 <= 1'b0;
      valid1 <= 1'b0;
    end
  end

  generate
    if (REPACK != 0) begin : g_repack
      logic [DW-1:0] dout_r;
      logic          data_ok_r;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_r    <= '0;
          data_ok_r <= 1'b0;
        end else begin
          dout_r    <= dout_c;
          data_ok_r <= data_ok_c;
        end
      end

      assign dout    = dout_r;
      assign data_ok = data_ok_r;
    end else begin : g_direct
      assign dout    = dout_c;
      assign data_ok = data_ok_c;
    end
  endgenerate

endmodule

// File: tb/tb_jtframe_rom_rq.sv
// Directed bench: byte, half-word and registered-byte slots fed the same stimulus.
module tb_jtframe_rom_rq;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic [21:0] offset;
  logic [7:0]  addr;
  logic        addr_ok;
  logic [31:0] din;
  logic        din_ok;
  logic        we;

  logic [21:0] sa8, sa16, sar;
  logic        req8, req16, reqr;
  logic        ok8, ok16, okr;
  logic [7:0]  do8, dor;
  logic [15:0] do16;

  int checks = 0;
  int errors = 0;

  jtframe_rom_rq #(.AW(8), .DW(8), .REPACK(0)) u8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .offset(offset), .addr(addr),
    .addr_ok(addr_ok), .sdram_addr(sa8), .din(din), .din_ok(din_ok),
    .we(we), .req(req8), .data_ok(ok8), .dout(do8)
  );

  jtframe_rom_rq #(.AW(8), .DW(16), .REPACK(0)) u16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .offset(offset), .addr(addr),
    .addr_ok(addr_ok), .sdram_addr(sa16), .din(din), .din_ok(din_ok),
    .we(we), .req(req16), .data_ok(ok16), .dout(do16)
  );

  jtframe_rom_rq #(.AW(8), .DW(8), .REPACK(1)) u8r (
    .clk(clk), .rst_n(rst_n), .clr(clr), .offset(offset), .addr(addr),
    .addr_ok(addr_ok), .sdram_addr(sar), .din(din), .din_ok(din_ok),
    .we(we), .req(reqr), .data_ok(okr), .dout(dor)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; offset = 22'h001000; addr = 8'h13;
    addr_ok = 1'b1; din = '0; din_ok = 1'b0; we = 1'b0;
    #2;
    chk("rst_req8", 32'(req8), 1);
    chk("rst_sa8", 32'(sa8), 32'h001008);
    chk("rst_ok8", 32'(ok8), 0);
    chk("rst_sa16", 32'(sa16), 32'h001012);
    chk("rst_okr", 32'(okr), 0);
    chk("rst_dor", 32'(dor), 0);
    rst_n = 1'b1;
    tick();

    // line A: 0xDDCCBBAA at byte line 0x10
    we = 1'b1; #1;
    chk("grant_req8", 32'(req8), 0);
    tick();
    din = 32'hDDCCBBAA; din_ok = 1'b1; #1;
    chk("no_bypass_ok8", 32'(ok8), 0);
    tick();
    we = 1'b0; din_ok = 1'b0; #1;
    chk("fillA_ok8", 32'(ok8), 1);
    chk("fillA_do8", 32'(do8), 32'hDD);
    chk("fillA_req8", 32'(req8), 0);
    chk("fillA_okr_lag", 32'(okr), 0);
    chk("fillA_ok16", 32'(ok16), 1);
    chk("fillA_do16", 32'(do16), 32'hDDCC);
    tick();
    chk("fillA_okr", 32'(okr), 1);
    chk("fillA_dor", 32'(dor), 32'hDD);
    addr = 8'h10; #1;
    chk("a10_do8", 32'(do8), 32'hAA);
    chk("a10_req8", 32'(req8), 0);
    chk("a10_ok8", 32'(ok8), 1);
    chk("a10_dor_old", 32'(dor), 32'hDD);
    chk("a10_req16", 32'(req16), 1);
    tick();
    chk("a10_dor", 32'(dor), 32'hAA);

    // line B: 0x12345678 at address 0x05
    addr = 8'h05; #1;
    chk("b_sa16", 32'(sa16), 32'h001004);
    chk("b_sa8", 32'(sa8), 32'h001002);
    chk("b_req8", 32'(req8), 1);
    we = 1'b1; tick();
    din = 32'h12345678; din_ok = 1'b1; tick();
    we = 1'b0; din_ok = 1'b0; #1;
    chk("b_ok16", 32'(ok16), 1);
    chk("b_do16", 32'(do16), 32'h1234);
    chk("b_do8", 32'(do8), 32'h56);
    addr = 8'h10; #1;
    chk("a_entry1_ok8", 32'(ok8), 1);
    chk("a_entry1_do8", 32'(do8), 32'hAA);

    // line C evicts A
    addr = 8'h20; we = 1'b1; tick();
    din = 32'hCAFEF00D; din_ok = 1'b1; tick();
    we = 1'b0; din_ok = 1'b0; #1;
    chk("c_do8", 32'(do8), 32'h0D);
    addr = 8'h10; #1;
    chk("a_evict_req8", 32'(req8), 1);
    chk("a_evict_ok8", 32'(ok8), 0);
    addr = 8'h05; #1;
    chk("b_keep_ok8", 32'(ok8), 1);
    chk("b_keep_do8", 32'(do8), 32'h56);
    addr = 8'h22; #1;
    chk("c_sel2_do8", 32'(do8), 32'hFE);

    // clr together with a fill: new line survives, shifted line dies
    addr = 8'h10; we = 1'b1; clr = 1'b1; din = 32'h11223344; din_ok = 1'b1;
    tick();
    we = 1'b0; clr = 1'b0; din_ok = 1'b0; addr = 8'h11; #1;
    chk("clrfill_ok8", 32'(ok8), 1);
    chk("clrfill_do8", 32'(do8), 32'h33);
    addr = 8'h22; #1;
    chk("clrfill_e1_req8", 32'(req8), 1);
    addr = 8'h05; #1;
    chk("clrfill_b_req8", 32'(req8), 1);

    clr = 1'b1; tick();
    clr = 1'b0; addr = 8'h11; #1;
    chk("clr_req8", 32'(req8), 1);
    chk("clr_ok8", 32'(ok8), 0);

    addr_ok = 1'b0; #1;
    chk("cs_low_req8", 32'(req8), 0);
    addr_ok = 1'b1;

    // refill at 0x05 then check wrap-around of the translated address
    addr = 8'h05; we = 1'b1; tick();
    din = 32'h55667788; din_ok = 1'b1; tick();
    we = 1'b0; din_ok = 1'b0; #1;
    chk("d_do8", 32'(do8), 32'h77);
    tick();
    chk("d_okr", 32'(okr), 1);
    chk("d_dor", 32'(dor), 32'h77);
    offset = 22'h3FFFFF; addr = 8'h04; #1;
    chk("wrap_sa8", 32'(sa8), 32'h000001);
    chk("wrap_sa16", 32'(sa16), 32'h000003);
    chk("pre_rst_ok8", 32'(ok8), 1);

    // reset in the middle of an access
    addr = 8'h08; we = 1'b1; tick();
    din = 32'h99999999; din_ok = 1'b1; #1;
    rst_n = 1'b0; #1;
    addr = 8'h04; #1;
    chk("midrst_ok8", 32'(ok8), 0);
    chk("midrst_okr", 32'(okr), 0);
    chk("midrst_dor", 32'(dor), 0);
    we = 1'b0; din_ok = 1'b0; #1;
    chk("midrst_req8", 32'(req8), 1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ok8", 32'(ok8), 0);
    chk("post_rst_req8", 32'(req8), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
